// File: rtl/lambertian_shader_multi_pkg.sv
// Shared types and constants for the multi-light Lambertian shader.
//   rgb_t    : packed {r,g,b} colour, DEF_COLOR_BITS per channel
//   vec3_t   : packed {x,y,z} signed fixed-point vector, DEF_WIDTH per component
//   ONE_Q    : fixed-point 1.0 for the default Q format
//   state_e  : shader FSM state encoding
package lambertian_shader_multi_pkg;

    localparam int unsigned DEF_WIDTH      = 24;
    localparam int unsigned DEF_Q_BITS     = 12;
    localparam int unsigned DEF_NUM_LIGHTS = 4;
    localparam int unsigned DEF_COLOR_BITS = 8;

    localparam int unsigned ONE_Q = 1 << DEF_Q_BITS;

    typedef logic [DEF_COLOR_BITS-1:0] chan_t;
    typedef logic signed [DEF_WIDTH-1:0] comp_t;

    typedef struct packed {
        chan_t r;
        chan_t g;
        chan_t b;
    } rgb_t;

    typedef struct packed {
        comp_t x;
        comp_t y;
        comp_t z;
    } vec3_t;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StModulate,
        StHold
    } state_e;

endpackage

// File: rtl/lambertian_shader_multi_if.sv
// Handshake bundle for lambertian_shader_multi.
//   Input side : in_valid/in_ready, normal_in, albedo_in, light_dir_in, light_color_in,
//                light_en_in (and ambient_in when LAMBERT_AMBIENT_EN is defined)
//   Output side: out_valid/out_ready, color_out
// Modports: slave = shader view, master = producer/consumer view.
// Optional macro: LAMBERT_AMBIENT_EN adds ambient_in.
interface lambertian_shader_multi_if #(
    parameter int unsigned WIDTH      = 24,
    parameter int unsigned COLOR_BITS = 8,
    parameter int unsigned NUM_LIGHTS = 4
) ();

    logic                             in_valid;
    logic                             in_ready;
    logic [3*WIDTH-1:0]               normal_in;
    logic [3*COLOR_BITS-1:0]          albedo_in;
    logic [NUM_LIGHTS*3*WIDTH-1:0]    light_dir_in;
    logic [NUM_LIGHTS*3*COLOR_BITS-1:0] light_color_in;
    logic [NUM_LIGHTS-1:0]            light_en_in;
`ifdef LAMBERT_AMBIENT_EN
    logic [3*COLOR_BITS-1:0]          ambient_in;
`endif
    logic                             out_valid;
    logic                             out_ready;
    logic [3*COLOR_BITS-1:0]          color_out;

`ifdef LAMBERT_AMBIENT_EN
    modport slave (
        input  in_valid, normal_in, albedo_in, light_dir_in, light_color_in, light_en_in,
        input  ambient_in, out_ready,
        output in_ready, out_valid, color_out
    );
    modport master (
        output in_valid, normal_in, albedo_in, light_dir_in, light_color_in, light_en_in,
        output ambient_in, out_ready,
        input  in_ready, out_valid, color_out
    );
`else
    modport slave (
        input  in_valid, normal_in, albedo_in, light_dir_in, light_color_in, light_en_in,
        input  out_ready,
        output in_ready, out_valid, color_out
    );
    modport master (
        output in_valid, normal_in, albedo_in, light_dir_in, light_color_in, light_en_in,
        output out_ready,
        input  in_ready, out_valid, color_out
    );
`endif

endinterface

// File: rtl/lambertian_shader_multi_dot_clamp.sv
// lambert_dot_clamp: combinational N.L for signed fixed-point vectors.
//   n_i, l_i : {x,y,z}, WIDTH bits per component, Q_BITS fractional bits
//   dot_o    : (N.L >>> Q_BITS) clamped to [0, 1.0], Q_BITS+1 bits unsigned
module lambert_dot_clamp #(
    parameter int unsigned WIDTH  = 24,
    parameter int unsigned Q_BITS = 12
) (
    input  logic [3*WIDTH-1:0] n_i,
    input  logic [3*WIDTH-1:0] l_i,
    output logic [Q_BITS:0]    dot_o
);

    localparam int unsigned SUM_W = 2 * WIDTH + 2;

    logic signed [2*WIDTH-1:0] prod [3];
    logic signed [SUM_W-1:0]   sum;
    logic signed [SUM_W-1:0]   shifted;
    logic signed [SUM_W-1:0]   one;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            prod[i] = $signed(n_i[i*WIDTH +: WIDTH]) * $signed(l_i[i*WIDTH +: WIDTH]);
        end
        sum     = SUM_W'(prod[0]) + SUM_W'(prod[1]) + SUM_W'(prod[2]);
        shifted = sum >>> Q_BITS;
        one     = '0;
        one[Q_BITS] = 1'b1;
        if (shifted[SUM_W-1]) begin
            dot_o = '0;
        end else if (shifted > one) begin
            dot_o = one[Q_BITS:0];
        end else begin
            dot_o = shifted[Q_BITS:0];
        end
    end

endmodule

// File: rtl/lambertian_shader_multi.sv
// lambertian_shader_multi: shades one hit against NUM_LIGHTS directional lights, one per
// cycle, then modulates the saturated sum by the albedo.
//   clk, reset : clock, synchronous active-high reset
//   bus        : lambertian_shader_multi_if.slave (input and output valid/ready channels)
// Latency from accept edge to out_valid is NUM_LIGHTS+2 regardless of the enable mask.
// Optional macro: LAMBERT_AMBIENT_EN seeds the accumulators with ambient_in.
module lambertian_shader_multi
    import lambertian_shader_multi_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned Q_BITS     = DEF_Q_BITS,
    parameter int unsigned NUM_LIGHTS = DEF_NUM_LIGHTS,
    parameter int unsigned COLOR_BITS = DEF_COLOR_BITS
) (
    input logic                    clk,
    input logic                    reset,
    lambertian_shader_multi_if.slave bus
);

    localparam int unsigned ACC_W   = COLOR_BITS + $clog2(NUM_LIGHTS + 2);
    localparam int unsigned IDX_W   = $clog2(NUM_LIGHTS + 1);
    localparam int unsigned LP_W    = Q_BITS + COLOR_BITS + 1;
    localparam int unsigned MP_W    = 2 * COLOR_BITS + 1;
    localparam int unsigned LIT_MAX = (1 << COLOR_BITS) - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LIGHTS);

    state_e                             state_q, state_d;
    logic [IDX_W-1:0]                   idx_q, idx_d;
    logic [ACC_W-1:0]                   acc_q [3];
    logic [ACC_W-1:0]                   acc_d [3];
    logic [COLOR_BITS-1:0]              contrib_q [3];
    logic [COLOR_BITS-1:0]              contrib_d [3];
    logic [3*COLOR_BITS-1:0]            color_q, color_d;

    // Transaction capture (data only, no reset needed)
    logic [3*WIDTH-1:0]                 normal_q;
    logic [3*COLOR_BITS-1:0]            albedo_q;
    logic [NUM_LIGHTS*3*WIDTH-1:0]      dir_q;
    logic [NUM_LIGHTS*3*COLOR_BITS-1:0] lcol_q;
    logic [NUM_LIGHTS-1:0]              en_q;

    logic                               accept;
    logic [3*WIDTH-1:0]                 cur_dir;
    logic [3*COLOR_BITS-1:0]            cur_col;
    logic                               cur_en;
    logic [Q_BITS:0]                    dot;
    logic [LP_W-1:0]                    lprod [3];
    logic [COLOR_BITS-1:0]              contrib_calc [3];
    logic [COLOR_BITS-1:0]              lit [3];
    logic [MP_W-1:0]                    mprod [3];
    logic [3*COLOR_BITS-1:0]            color_calc;
    logic [ACC_W-1:0]                   acc_init [3];
    logic                               unused_lo;

    lambert_dot_clamp #(
        .WIDTH  (WIDTH),
        .Q_BITS (Q_BITS)
    ) u_dot (
        .n_i   (normal_q),
        .l_i   (cur_dir),
        .dot_o (dot)
    );

    // Light slot mux; idx == NUM_LIGHTS is the drain cycle and selects nothing.
    always_comb begin
        cur_dir = '0;
        cur_col = '0;
        cur_en  = 1'b0;
        for (int i = 0; i < NUM_LIGHTS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_dir = dir_q[i*3*WIDTH +: 3*WIDTH];
                cur_col = lcol_q[i*3*COLOR_BITS +: 3*COLOR_BITS];
                cur_en  = en_q[i];
            end
        end
    end

    // Per-channel contribution and albedo modulation datapaths
    always_comb begin
        color_calc = '0;
        unused_lo  = 1'b0;
        for (int ch = 0; ch < 3; ch++) begin
            lprod[ch] = LP_W'(dot) * LP_W'(cur_col[ch*COLOR_BITS +: COLOR_BITS]);
            contrib_calc[ch] = lprod[ch][LP_W-1] ? '1 : lprod[ch][Q_BITS +: COLOR_BITS];

            lit[ch] = (acc_q[ch] > ACC_W'(LIT_MAX)) ? '1 : acc_q[ch][COLOR_BITS-1:0];
            // albedo+1 makes full-scale albedo an exact identity
            mprod[ch] = MP_W'(lit[ch])
                      * (MP_W'(albedo_q[ch*COLOR_BITS +: COLOR_BITS]) + MP_W'(1));
            color_calc[ch*COLOR_BITS +: COLOR_BITS] =
                mprod[ch][MP_W-1] ? '1 : mprod[ch][COLOR_BITS +: COLOR_BITS];

            unused_lo = unused_lo ^ (^lprod[ch][Q_BITS-1:0]) ^ (^mprod[ch][COLOR_BITS-1:0]);
        end
    end

    always_comb begin
        for (int ch = 0; ch < 3; ch++) begin
`ifdef LAMBERT_AMBIENT_EN
            acc_init[ch] = ACC_W'(bus.ambient_in[ch*COLOR_BITS +: COLOR_BITS]);
`else
            acc_init[ch] = '0;
`endif
        end
    end

    // Contribution is registered before accumulation to keep the multiply chain short,
    // so ACCUM spends one extra drain cycle adding the last light.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        contrib_d = contrib_q;
        color_d   = color_q;
        accept    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    idx_d   = '0;
                    acc_d   = acc_init;
                    for (int ch = 0; ch < 3; ch++) contrib_d[ch] = '0;
                    state_d = StAccum;
                end
            end
            StAccum: begin
                for (int ch = 0; ch < 3; ch++) begin
                    acc_d[ch]     = acc_q[ch] + ACC_W'(contrib_q[ch]);
                    contrib_d[ch] = cur_en ? contrib_calc[ch] : '0;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = StModulate;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StModulate: begin
                color_d = color_calc;
                state_d = StHold;
            end
            StHold: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            color_q <= '0;
            for (int ch = 0; ch < 3; ch++) begin
                acc_q[ch]     <= '0;
                contrib_q[ch] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            color_q   <= color_d;
            acc_q     <= acc_d;
            contrib_q <= contrib_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            normal_q <= bus.normal_in;
            albedo_q <= bus.albedo_in;
            dir_q    <= bus.light_dir_in;
            lcol_q   <= bus.light_color_in;
            en_q     <= bus.light_en_in;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StHold);
    assign bus.color_out = color_q;

endmodule

// File: tb/tb_lambertian_shader_multi.sv
// Scoreboard bench for lambertian_shader_multi: the driver pushes hand-computed colours
// at acceptance; a monitor pops and compares colour and latency when out_valid appears.
module tb_lambertian_shader_multi;
    import lambertian_shader_multi_pkg::*;

    localparam int unsigned W   = 24;
    localparam int unsigned Q   = 12;
    localparam int unsigned NL  = 4;
    localparam int unsigned CB  = 8;
    localparam int          LAT = NL + 2;

    typedef struct {
        rgb_t rgb;
        int   acc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lambertian_shader_multi_if #(.WIDTH(W), .COLOR_BITS(CB), .NUM_LIGHTS(NL)) bus ();

    lambertian_shader_multi #(
        .WIDTH      (W),
        .Q_BITS     (Q),
        .NUM_LIGHTS (NL),
        .COLOR_BITS (CB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   nvec = 0;
    int   nerr = 0;
    int   ncyc = 0;
    exp_t q[$];
    exp_t cur;
    exp_t dropped;
    bit   seen = 1'b0;
    rgb_t last_amb;

    logic [NL*3*W-1:0]  dirs;
    logic [NL*3*CB-1:0] cols;
    logic [NL-1:0]      en;

    always @(posedge clk) ncyc <= ncyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic vec3_t v3(input int x, input int y, input int z);
        vec3_t v;
        v.x = comp_t'(x);
        v.y = comp_t'(y);
        v.z = comp_t'(z);
        return v;
    endfunction

    function automatic rgb_t rgb(input int r, input int g, input int b);
        rgb_t c;
        c.r = chan_t'(r);
        c.g = chan_t'(g);
        c.b = chan_t'(b);
        return c;
    endfunction

    task automatic set_light(input int i, input vec3_t d, input rgb_t c);
        dirs[i*3*W +: 3*W] = d;
        cols[i*3*CB +: 3*CB] = c;
    endtask

    // Disabled slots keep a bright aligned light so an ignored enable shows up.
    task automatic clear_lights();
        for (int i = 0; i < NL; i++) set_light(i, v3(0, 0, ONE_Q), rgb(255, 255, 255));
        en = '0;
    endtask

    // Call at a negedge. Returns #1 after the accepting edge.
    task automatic send(input vec3_t n, input rgb_t alb, input rgb_t amb, input rgb_t exp,
                        output int waits);
        exp_t e;
        waits = 0;
        last_amb = amb;
        bus.normal_in      = n;
        bus.albedo_in      = alb;
        bus.light_dir_in   = dirs;
        bus.light_color_in = cols;
        bus.light_en_in    = en;
`ifdef LAMBERT_AMBIENT_EN
        bus.ambient_in     = amb;
`endif
        bus.in_valid       = 1'b1;
        while (!bus.in_ready && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        if (!bus.in_ready) begin
            nvec++;
            nerr++;
            $display("FAIL accept_timeout: in_ready got 0, required 1");
            bus.in_valid = 1'b0;
            return;
        end
        e.rgb = exp;
        e.acc = ncyc;
        q.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid       = 1'b0;
        bus.normal_in      = ~bus.normal_in;
        bus.albedo_in      = ~bus.albedo_in;
        bus.light_dir_in   = ~bus.light_dir_in;
        bus.light_color_in = ~bus.light_color_in;
        bus.light_en_in    = ~bus.light_en_in;
    endtask

    task automatic shade(input vec3_t n, input rgb_t alb, input rgb_t amb, input rgb_t exp);
        int w;
        @(negedge clk);
        send(n, alb, amb, exp, w);
    endtask

    task automatic drain();
        int t = 0;
        @(negedge clk);
        while (!(q.size() == 0 && bus.in_ready && !bus.out_valid) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            nvec++;
            nerr++;
            $display("FAIL drain_timeout: pending results got %0d, required 0", q.size());
        end
    endtask

    // Monitor: first valid cycle pops the scoreboard, later held cycles must stay stable.
    always begin
        @(negedge clk);
        if (bus.out_valid) begin
            if (!seen) begin
                if (q.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_out: got out_valid 1 with no pending result");
                end else begin
                    cur = q.pop_front();
                    check("color", bus.color_out, cur.rgb);
                    check("latency", 64'(ncyc - cur.acc - 1), 64'(LAT));
                end
                seen = 1'b1;
            end else begin
                check("hold_stable", bus.color_out, cur.rgb);
            end
        end else begin
            seen = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time got exhausted, required to finish");
        $fatal(1);
    end

    initial begin
        vec3_t nz;
        int    w;
        int    t;

        nz = v3(0, 0, ONE_Q);
        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b1;
        bus.normal_in  = '0;
        bus.albedo_in  = '0;
        bus.light_dir_in   = '0;
        bus.light_color_in = '0;
        bus.light_en_in    = '0;
`ifdef LAMBERT_AMBIENT_EN
        bus.ambient_in = '0;
`endif
        clear_lights();
        repeat (3) @(negedge clk);
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_color", bus.color_out, 0);
        reset = 1'b0;

        // Aligned white light, albedo passes through
        clear_lights();
        set_light(0, v3(0, 0, ONE_Q), rgb(255, 255, 255));
        en = 4'b0001;
        shade(nz, rgb(255, 128, 0), rgb(0, 0, 0), rgb(255, 128, 0));

        // Light behind the surface
        set_light(0, v3(0, 0, -ONE_Q), rgb(255, 255, 255));
        shade(nz, rgb(255, 128, 0), rgb(0, 0, 0), rgb(0, 0, 0));

        // Half-strength dot: 2048*255>>12 = 127
        set_light(0, v3(0, 0, 2048), rgb(255, 255, 255));
        shade(nz, rgb(255, 255, 255), rgb(0, 0, 0), rgb(127, 127, 127));

        // Two white lights saturate; then all disabled
        clear_lights();
        en = 4'b0011;
        shade(nz, rgb(255, 255, 255), rgb(0, 0, 0), rgb(255, 255, 255));
        en = 4'b0000;
        shade(nz, rgb(255, 255, 255), rgb(0, 0, 0), rgb(0, 0, 0));

        // Dot above 1.0 clamps, last slot
        clear_lights();
        set_light(3, v3(0, 0, 8192), rgb(100, 50, 200));
        en = 4'b1000;
        shade(nz, rgb(255, 255, 255), rgb(0, 0, 0), rgb(100, 50, 200));

        // Mixed: (100,50,20)+(10,20,30) = (110,70,50); albedo (255,127,0) -> (110,35,0)
        clear_lights();
        set_light(0, v3(0, 0, 2048), rgb(200, 100, 40));
        set_light(2, v3(0, 0, ONE_Q), rgb(10, 20, 30));
        en = 4'b0101;
        shade(nz, rgb(255, 127, 0), rgb(0, 0, 0), rgb(110, 35, 0));

        // Diagonal: 2*2896^2>>12 = 4095, 4095*255>>12 = 254
        clear_lights();
        set_light(1, v3(2896, 0, 2896), rgb(255, 255, 255));
        en = 4'b0010;
        shade(v3(2896, 0, 2896), rgb(255, 255, 255), rgb(0, 0, 0), rgb(254, 254, 254));
        drain();

        // Backpressure, then handoff with in_valid already high
        bus.out_ready = 1'b0;
        clear_lights();
        set_light(0, v3(0, 0, ONE_Q), rgb(255, 255, 255));
        en = 4'b0001;
        shade(nz, rgb(255, 128, 0), rgb(0, 0, 0), rgb(255, 128, 0));
        t = 0;
        while (!bus.out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("bp_valid_seen", bus.out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_in_ready", bus.in_ready, 0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        set_light(0, v3(0, 0, 2048), rgb(255, 255, 255));
        send(nz, rgb(255, 255, 255), rgb(0, 0, 0), rgb(127, 127, 127), w);
        check("handoff_wait", w, 1);
        drain();

        // Reset mid-ACCUM aborts, then a clean transaction
        clear_lights();
        en = 4'b0011;
        shade(nz, rgb(255, 255, 255), rgb(0, 0, 0), rgb(255, 255, 255));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        dropped = q.pop_back();
        @(negedge clk);
        check("abort_in_ready", bus.in_ready, 1);
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_color", bus.color_out, 0);
        reset = 1'b0;
        clear_lights();
        set_light(0, v3(0, 0, 2048), rgb(200, 100, 40));
        set_light(2, v3(0, 0, ONE_Q), rgb(10, 20, 30));
        en = 4'b0101;
        shade(nz, rgb(255, 127, 0), rgb(0, 0, 0), rgb(110, 35, 0));
        drain();

`ifdef LAMBERT_AMBIENT_EN
        clear_lights();
        shade(nz, rgb(255, 255, 255), rgb(20, 20, 20), rgb(20, 20, 20));
        en = 4'b0001;
        shade(nz, rgb(255, 255, 255), rgb(200, 200, 200), rgb(255, 255, 255));
        drain();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
